// File: rtl/pc_ctrl_pkg.sv
// Shared definitions for the fetch PC controller: word size, FSM encodings and
// the saturating redirect counter helper.
package pc_ctrl_pkg;

  localparam int WORD_SIZE = 16;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_JR_WAIT = 2'd1,
    ST_HALTED  = 2'd2
  } pc_state_e;

  localparam logic [15:0] REDIRECT_MAX = 16'hFFFF;

  function automatic logic [15:0] sat_inc16(input logic [15:0] value);
    return (value == REDIRECT_MAX) ? value : value + 16'd1;
  endfunction

endpackage

// File: rtl/pc_ctrl.sv
// Fetch PC controller: static not-taken prediction, ID-stage branch/jump
// redirects, EX-resolved register jumps with a timeout, and a sticky halt.
module pc_ctrl
  import pc_ctrl_pkg::*;
#(
  parameter int                     WORD_SIZE  = pc_ctrl_pkg::WORD_SIZE,
  parameter logic [WORD_SIZE-1:0]   RESET_PC   = '0,
  parameter int                     JR_TIMEOUT = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 stall,
  input  logic                 halt,
  input  logic                 id_valid,
  input  logic                 id_is_branch,
  input  logic                 id_cond,
  input  logic                 id_is_jump,
  input  logic [WORD_SIZE-1:0] id_target,
  input  logic                 id_is_jreg,
  input  logic                 ex_jr_valid,
  input  logic [WORD_SIZE-1:0] ex_target,
  output logic [WORD_SIZE-1:0] pc,
  output logic                 if_flush,
  output logic [1:0]           state,
  output logic [15:0]          redirect_cnt,
  output logic                 jr_err
);

  localparam int WW = (JR_TIMEOUT < 1) ? 1 : $clog2(JR_TIMEOUT + 1);
  localparam logic [WW-1:0] TIMEOUT_W = WW'(JR_TIMEOUT);

  logic [WORD_SIZE-1:0] pc_q, pc_d;
  logic [1:0]           state_q;
  pc_state_e            cur_state, state_d;
  logic [WW-1:0]        wait_q, wait_d;
  logic [15:0]          cnt_q, cnt_d;
  logic                 err_q, err_d;
  logic                 flush_c;
  logic                 id_taken;

  // Encoding 3 is unreachable but must behave as HALTED if it ever appears.
  always_comb begin
    if (state_q == 2'd3) cur_state = ST_HALTED;
    else                 cur_state = pc_state_e'(state_q);
  end

  assign id_taken = id_valid && ((id_is_branch && id_cond) || id_is_jump);

  // NOTE: every output of this block gets a default first so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    pc_d    = pc_q;
    state_d = cur_state;
    wait_d  = wait_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    flush_c = 1'b0;
    case (cur_state)
      ST_RUN: begin
        if (halt && id_valid) begin
          flush_c = 1'b1;
          state_d = ST_HALTED;
        end else if (stall) begin
          // Load-use hold: freeze and leave the ID instruction in place.
        end else if (id_valid && id_is_jreg) begin
          flush_c = 1'b1;
          state_d = ST_JR_WAIT;
          wait_d  = '0;
        end else if (id_taken) begin
          flush_c = 1'b1;
          pc_d    = id_target;
          cnt_d   = sat_inc16(cnt_q);
        end else begin
          pc_d = pc_q + WORD_SIZE'(1);
        end
      end
      ST_JR_WAIT: begin
        flush_c = 1'b1;
        if (ex_jr_valid) begin
          pc_d    = ex_target;
          cnt_d   = sat_inc16(cnt_q);
          state_d = ST_RUN;
        end else if (wait_q == TIMEOUT_W) begin
          err_d = 1'b1;
        end else begin
          wait_d = wait_q + WW'(1);
        end
      end
      default: begin
        flush_c = 1'b1;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_q    <= RESET_PC;
      state_q <= ST_RUN;
      wait_q  <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      state_q <= state_d;
      wait_q  <= wait_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // The flush is combinational, so gate it with reset to keep it low while
  // reset is held even if the ID inputs request a redirect.
  assign if_flush     = flush_c & reset_n;
  assign pc           = pc_q;
  assign state        = state_q;
  assign redirect_cnt = cnt_q;
  assign jr_err       = err_q;

endmodule

// File: tb/tb_pc_ctrl.sv
// Directed testbench for pc_ctrl: reset, sequential fetch, branches, stall,
// register jumps with timeout, PC wrap, halt and asynchronous reset.
module tb_pc_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        stall, halt, id_valid, id_is_branch, id_cond, id_is_jump;
  logic [15:0] id_target;
  logic        id_is_jreg, ex_jr_valid;
  logic [15:0] ex_target;
  logic [15:0] pc;
  logic        if_flush;
  logic [1:0]  state;
  logic [15:0] redirect_cnt;
  logic        jr_err;

  int total = 0;
  int bad   = 0;
  logic [15:0] exp_cnt;

  always #5 clk = ~clk;

  pc_ctrl #(.WORD_SIZE(16), .RESET_PC(16'h0000), .JR_TIMEOUT(4)) dut (
    .clk(clk), .reset_n(reset_n), .stall(stall), .halt(halt),
    .id_valid(id_valid), .id_is_branch(id_is_branch), .id_cond(id_cond),
    .id_is_jump(id_is_jump), .id_target(id_target), .id_is_jreg(id_is_jreg),
    .ex_jr_valid(ex_jr_valid), .ex_target(ex_target), .pc(pc),
    .if_flush(if_flush), .state(state), .redirect_cnt(redirect_cnt),
    .jr_err(jr_err)
  );

  task automatic clear_inputs();
    stall = 0; halt = 0; id_valid = 0; id_is_branch = 0; id_cond = 0;
    id_is_jump = 0; id_target = 16'h0000; id_is_jreg = 0;
    ex_jr_valid = 0; ex_target = 16'h0000;
  endtask

  // Advance one edge and settle just after it, away from the active edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Take an unconditional jump to a known PC (one redirect).
  task automatic jump_to(input logic [15:0] tgt);
    clear_inputs();
    id_valid = 1; id_is_jump = 1; id_target = tgt;
    step();
    exp_cnt = exp_cnt + 16'd1;
    clear_inputs();
    #1;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset_n = 0;
    id_valid = 1; id_is_jump = 1; id_target = 16'h0077;
    #3;
    total++; if (pc !== 16'h0000) begin bad++; $display("FAIL reset_pc got=%h want=0000", pc); end
    total++; if (state !== 2'd0) begin bad++; $display("FAIL reset_state got=%0d want=0", state); end
    total++; if (redirect_cnt !== 16'h0000) begin bad++; $display("FAIL reset_cnt got=%h want=0000", redirect_cnt); end
    total++; if (jr_err !== 1'b0) begin bad++; $display("FAIL reset_jr_err got=%b want=0", jr_err); end
    total++; if (if_flush !== 1'b0) begin bad++; $display("FAIL reset_flush got=%b want=0", if_flush); end
    clear_inputs();
    exp_cnt = 16'h0000;
    @(negedge clk);
    reset_n = 1;
    for (int i = 1; i <= 3; i++) begin
      step();
      total++; if (pc !== 16'(i)) begin bad++; $display("FAIL seq_pc got=%h want=%h", pc, 16'(i)); end
    end
    total++; if (redirect_cnt !== 16'h0000) begin bad++; $display("FAIL seq_cnt got=%h want=0000", redirect_cnt); end
  endtask

  task automatic test_branch();
    id_valid = 1; id_is_jump = 1; id_target = 16'h0010;
    #1;
    total++; if (if_flush !== 1'b1) begin bad++; $display("FAIL jmp_flush got=%b want=1", if_flush); end
    step();
    exp_cnt = exp_cnt + 16'd1;
    total++; if (pc !== 16'h0010) begin bad++; $display("FAIL jmp_pc got=%h want=0010", pc); end
    clear_inputs();
    id_valid = 1; id_is_branch = 1; id_cond = 1; id_target = 16'h0020;
    #1;
    total++; if (if_flush !== 1'b1) begin bad++; $display("FAIL beq_flush got=%b want=1", if_flush); end
    step();
    exp_cnt = exp_cnt + 16'd1;
    total++; if (pc !== 16'h0020) begin bad++; $display("FAIL beq_pc got=%h want=0020", pc); end
    total++; if (redirect_cnt !== exp_cnt) begin bad++; $display("FAIL beq_cnt got=%h want=%h", redirect_cnt, exp_cnt); end
    clear_inputs();
    #1;
    total++; if (if_flush !== 1'b0) begin bad++; $display("FAIL beq_flush_once got=%b want=0", if_flush); end
    jump_to(16'h0010);
    id_valid = 1; id_is_branch = 1; id_cond = 0; id_target = 16'h0020;
    #1;
    total++; if (if_flush !== 1'b0) begin bad++; $display("FAIL bnt_flush got=%b want=0", if_flush); end
    step();
    total++; if (pc !== 16'h0011) begin bad++; $display("FAIL bnt_pc got=%h want=0011", pc); end
    total++; if (redirect_cnt !== exp_cnt) begin bad++; $display("FAIL bnt_cnt got=%h want=%h", redirect_cnt, exp_cnt); end
    clear_inputs();
  endtask

  task automatic test_stall();
    stall = 1; id_valid = 1; id_is_jump = 1; id_target = 16'h0040;
    #1;
    total++; if (if_flush !== 1'b0) begin bad++; $display("FAIL stall_flush got=%b want=0", if_flush); end
    step();
    step();
    total++; if (pc !== 16'h0011) begin bad++; $display("FAIL stall_pc got=%h want=0011", pc); end
    total++; if (redirect_cnt !== exp_cnt) begin bad++; $display("FAIL stall_cnt got=%h want=%h", redirect_cnt, exp_cnt); end
    stall = 0;
    #1;
    total++; if (if_flush !== 1'b1) begin bad++; $display("FAIL unstall_flush got=%b want=1", if_flush); end
    step();
    exp_cnt = exp_cnt + 16'd1;
    total++; if (pc !== 16'h0040) begin bad++; $display("FAIL unstall_pc got=%h want=0040", pc); end
    clear_inputs();
  endtask

  task automatic test_invalid();
    id_valid = 0; id_is_jump = 1; id_is_jreg = 1; halt = 1; id_target = 16'h0099;
    #1;
    total++; if (if_flush !== 1'b0) begin bad++; $display("FAIL inval_flush got=%b want=0", if_flush); end
    step();
    total++; if (pc !== 16'h0041) begin bad++; $display("FAIL inval_pc got=%h want=0041", pc); end
    total++; if (state !== 2'd0) begin bad++; $display("FAIL inval_state got=%0d want=0", state); end
    clear_inputs();
  endtask

  task automatic test_jreg();
    jump_to(16'h0005);
    id_valid = 1; id_is_jreg = 1;
    #1;
    total++; if (if_flush !== 1'b1) begin bad++; $display("FAIL jpr_flush got=%b want=1", if_flush); end
    step();
    total++; if (state !== 2'd1) begin bad++; $display("FAIL jpr_state got=%0d want=1", state); end
    total++; if (pc !== 16'h0005) begin bad++; $display("FAIL jpr_pc_hold got=%h want=0005", pc); end
    clear_inputs();
    stall = 1;
    #1;
    total++; if (if_flush !== 1'b1) begin bad++; $display("FAIL jrw_flush got=%b want=1", if_flush); end
    step();
    total++; if (state !== 2'd1) begin bad++; $display("FAIL jrw_state2 got=%0d want=1", state); end
    total++; if (pc !== 16'h0005) begin bad++; $display("FAIL jrw_pc_hold got=%h want=0005", pc); end
    stall = 0; ex_jr_valid = 1; ex_target = 16'h0100;
    #1;
    total++; if (if_flush !== 1'b1) begin bad++; $display("FAIL jrv_flush got=%b want=1", if_flush); end
    step();
    exp_cnt = exp_cnt + 16'd1;
    total++; if (pc !== 16'h0100) begin bad++; $display("FAIL jrv_pc got=%h want=0100", pc); end
    total++; if (state !== 2'd0) begin bad++; $display("FAIL jrv_state got=%0d want=0", state); end
    total++; if (redirect_cnt !== exp_cnt) begin bad++; $display("FAIL jrv_cnt got=%h want=%h", redirect_cnt, exp_cnt); end
    clear_inputs();
    id_valid = 1; id_is_jreg = 1;
    step();
    clear_inputs();
    for (int i = 0; i < 3; i++) step();
    total++; if (jr_err !== 1'b0) begin bad++; $display("FAIL jr_err_early got=%b want=0", jr_err); end
    step();
    step();
    total++; if (jr_err !== 1'b1) begin bad++; $display("FAIL jr_err_timeout got=%b want=1", jr_err); end
    total++; if (state !== 2'd1) begin bad++; $display("FAIL jr_timeout_state got=%0d want=1", state); end
    ex_jr_valid = 1; ex_target = 16'h0200;
    step();
    exp_cnt = exp_cnt + 16'd1;
    clear_inputs();
    total++; if (pc !== 16'h0200) begin bad++; $display("FAIL jr_late_pc got=%h want=0200", pc); end
    total++; if (jr_err !== 1'b1) begin bad++; $display("FAIL jr_err_sticky got=%b want=1", jr_err); end
  endtask

  task automatic test_wrap_halt();
    jump_to(16'hFFFF);
    total++; if (pc !== 16'hFFFF) begin bad++; $display("FAIL wrap_pre got=%h want=ffff", pc); end
    step();
    total++; if (pc !== 16'h0000) begin bad++; $display("FAIL wrap_pc got=%h want=0000", pc); end
    step();
    total++; if (redirect_cnt !== exp_cnt) begin bad++; $display("FAIL wrap_cnt got=%h want=%h", redirect_cnt, exp_cnt); end
    halt = 1; id_valid = 1;
    #1;
    total++; if (if_flush !== 1'b1) begin bad++; $display("FAIL halt_flush got=%b want=1", if_flush); end
    step();
    clear_inputs();
    total++; if (state !== 2'd2) begin bad++; $display("FAIL halt_state got=%0d want=2", state); end
    for (int i = 0; i < 10; i++) begin
      id_valid = 1; id_is_jump = (i % 2 == 0); id_is_jreg = (i % 3 == 0);
      ex_jr_valid = 1; ex_target = 16'h0300; id_target = 16'h0400;
      step();
      total++;
      if (pc !== 16'h0001 || state !== 2'd2 || if_flush !== 1'b1) begin
        bad++;
        $display("FAIL halted_hold cyc=%0d got pc=%h st=%0d fl=%b want pc=0001 st=2 fl=1",
                 i, pc, state, if_flush);
      end
    end
    total++; if (redirect_cnt !== exp_cnt) begin bad++; $display("FAIL halted_cnt got=%h want=%h", redirect_cnt, exp_cnt); end
    clear_inputs();
    #2;
    reset_n = 0;
    #1;
    exp_cnt = 16'h0000;
    total++; if (pc !== 16'h0000 || state !== 2'd0) begin bad++; $display("FAIL async_rst got pc=%h st=%0d want pc=0000 st=0", pc, state); end
    total++; if (redirect_cnt !== 16'h0000 || jr_err !== 1'b0) begin bad++; $display("FAIL async_rst_cnt got cnt=%h err=%b want 0000/0", redirect_cnt, jr_err); end
    @(negedge clk);
    reset_n = 1;
    step();
    total++; if (pc !== 16'h0001) begin bad++; $display("FAIL post_rst_pc got=%h want=0001", pc); end
  endtask

  initial begin
    exp_cnt = 16'h0000;
    test_reset();
    test_branch();
    test_stall();
    test_invalid();
    test_jreg();
    test_wrap_halt();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Guard against a hung run.
  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule
